fetch_pc: RTL and testbench
===========================

# fetch_pc

Fetch-stage program-counter and instruction-fetch controller for the pipelined RV32I core. It consumes the branch unit's `PCSel` decision and the EX-stage targets, then issues requests to instruction memory over a req/ack handshake. It owns the IF/ID pipeline register. Redirect requests that arrive while a fetch is outstanding are held pending, and the stale response is discarded.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC fetched first after reset.
- `NOP_INST`, default 32'h0000_0013: value loaded into IF/ID on reset or flush (`addi x0,x0,0`).

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `PCSel`  in  2: redirect select.
  - 00: sequential.
  - 01: branch/jal, taken to `BrTarget`.
  - 10: jalr, taken to `JalrTarget`.
  - 11: treated as 00.
- `BrTarget`  in  32: EX-stage PC+imm.
- `JalrTarget`  in  32: EX-stage rs1+imm. Bit 0 is cleared here.
- `Stall`  in  1: load-use stall from the hazard unit. Holds IF/ID.
- `imem_req`  out  1: fetch request.
- `imem_addr`  out  32: fetch address. Stable while `imem_req`=1 and no ack.
- `imem_ack`  in  1: response valid this cycle. Only meaningful while `imem_req`=1.
- `imem_rdata`  in  32: instruction, valid with `imem_ack`.
- `Flush`  out  1: combinational, equal to `PCSel`==01 or 10. Kills the ID/EX contents downstream.
- `IfId_valid`  out  1: IF/ID holds a live instruction.
- `IfId_inst`  out  32: IF/ID instruction.
- `IfId_pc`  out  32: PC of `IfId_inst`.

## Operation
- Registers:
  - `pc`: address of the current request.
  - `pend`: pending redirect target.
  - `buf`: one-entry instruction buffer.
  - `state`.
- States:
  - S_RST: `imem_req`=0. Goes to S_REQ on the next edge.
  - S_REQ: `imem_req`=1, `imem_addr`=`pc`.
  - S_DROP: `imem_req`=1, `imem_addr`=old `pc`. The response will be discarded.
  - S_HOLD: `imem_req`=0. `buf` holds a fetched instruction not yet accepted because of `Stall`.
- Redirect (`PCSel` 01/10) has priority over `Stall` in every state. On redirect, IF/ID is loaded with `IfId_valid`=0 and `IfId_inst`=`NOP_INST`.
- Transitions in S_REQ:
  - ack & redirect: drop data, `pc`<=target, stay in S_REQ.
  - ack & Stall: `buf`<=rdata, go to S_HOLD. IF/ID is unchanged.
  - ack only: IF/ID<={1, rdata, `pc`}, `pc`<=`pc`+4, stay in S_REQ.
  - no ack & redirect: `pend`<=target, go to S_DROP.
  - no ack & Stall: no change.
- Transitions in S_DROP:
  - Any redirect updates `pend`, so the latest redirect wins.
  - On ack: discard data, `pc`<=`pend` (or the same-cycle target), go to S_REQ.
- Transitions in S_HOLD:
  - Redirect: discard `buf`, `pc`<=target, go to S_REQ.
  - `Stall` low: IF/ID<={1, `buf`, `pc`}, `pc`<=`pc`+4, go to S_REQ.
- Arithmetic and targets:
  - PC arithmetic is 32-bit, modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0.
  - `BrTarget` bits [1:0] are passed unchanged; misalignment is handled elsewhere.
  - `JalrTarget` is used as {[31:1],1'b0}.
- While `Stall`=1 and there is no redirect, IF/ID holds its value in all states.

## Timing
- Reset values:
  - `state`=S_RST, `pc`=`RESET_PC`, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `IfId_valid`=0, `IfId_inst`=`NOP_INST`, `IfId_pc`=0.
  - `Flush` tracks `PCSel`.
- Reset is asynchronous: outputs take their reset values immediately, including mid-S_DROP or mid-S_HOLD. Any outstanding response is ignored.
- First request is asserted one cycle after `rst` deasserts.
- With zero-wait memory (ack in the same cycle as req), throughput is 1 instruction per cycle. IF/ID updates on the edge that samples the ack.
- Redirect penalty:
  - 1 cycle when no fetch is outstanding or the ack coincides with the redirect.
  - 1 cycle plus the remaining memory latency when in S_DROP.

## Structure
- Shared package `core_pkg` holds:
  - `PCSel` encodings (`PC_SEQ`, `PC_BR`, `PC_JALR`).
  - `NOP_INST`.
  - The fetch state enum.
- One sub-module, `pc_next_sel`: a combinational mux producing the redirect target and a redirect flag from `PCSel`, `BrTarget` and `JalrTarget`.

## Test plan
- Reset and first fetch: `RESET_PC`=0x100, release `rst`, ack 0x00500093 on the first request.
  - Required: `imem_req`=0 for one cycle, then `imem_addr`=0x100.
  - Then IF/ID={1, 0x00500093, 0x100} and `imem_addr`=0x104.
- Taken branch coinciding with ack: `PCSel`=01, `BrTarget`=0x200.
  - Required: `Flush`=1 that cycle, `IfId_valid`=0 next cycle, `imem_addr`=0x200.
- jalr redirect: `PCSel`=10, `JalrTarget`=0x301.
  - Required: `imem_addr`=0x300 next cycle.
- Redirect during an outstanding fetch at 0x108: `PCSel`=01, `BrTarget`=0x200, ack 3 cycles later.
  - Required: `imem_addr` held at 0x108 until ack, data discarded (`IfId_valid`=0).
  - Then `imem_addr`=0x200.
- Stall on ack: fetch at 0x10C, `Stall`=1 for 2 cycles.
  - Required: `imem_req`=0 and IF/ID unchanged during the stall.
  - After release: IF/ID={1, buffered inst, 0x10C}, `imem_addr`=0x110.
- Async reset asserted mid-S_DROP.
  - Required: outputs at reset values before the next edge, and the late ack is ignored.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the RV32I pipeline front end.
//   - PCSel encodings driven by the branch unit
//   - NOP_INST: canonical bubble (addi x0,x0,0) loaded into IF/ID
//   - fetch_state_e: fetch controller states
package core_pkg;

  localparam logic [1:0] PC_SEQ  = 2'b00;
  localparam logic [1:0] PC_BR   = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // S_RST : idle for one cycle after reset, no request
  // S_REQ : request outstanding at pc
  // S_DROP: request outstanding at old pc, response will be discarded
  // S_HOLD: no request, buffered instruction waiting for Stall to drop
  typedef enum logic [1:0] {
    S_RST  = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2,
    S_HOLD = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect target mux.
// Ports:
//   PCSel      in  2  : redirect select (00/11 sequential, 01 branch, 10 jalr)
//   BrTarget   in  32 : PC+imm, passed unchanged
//   JalrTarget in  32 : rs1+imm, bit 0 forced to zero
//   target_o   out 32 : redirect target (don't care when redirect_o=0)
//   redirect_o out 1  : a redirect is requested this cycle
module pc_next_sel
  import core_pkg::*;
(
  input  logic [1:0]  PCSel,
  input  logic [31:0] BrTarget,
  input  logic [31:0] JalrTarget,
  output logic [31:0] target_o,
  output logic        redirect_o
);

  // JALR always lands on an even address; bit 0 is deliberately ignored.
  logic unused_jalr_bit0;
  assign unused_jalr_bit0 = JalrTarget[0];

  always_comb begin
    target_o   = BrTarget;
    redirect_o = 1'b0;
    case (PCSel)
      PC_BR: begin
        target_o   = BrTarget;
        redirect_o = 1'b1;
      end
      PC_JALR: begin
        target_o   = {JalrTarget[31:1], 1'b0};
        redirect_o = 1'b1;
      end
      default: begin
        target_o   = BrTarget;
        redirect_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fetch_pc.sv
// Fetch-stage PC and instruction-fetch controller; owns the IF/ID register.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   PCSel, BrTarget,
//   JalrTarget               : redirect request from EX / branch unit
//   Stall                    : load-use stall, holds IF/ID
//   imem_req/imem_addr       : fetch request, address stable until ack
//   imem_ack/imem_rdata      : fetch response
//   Flush                    : combinational, high on any redirect
//   IfId_valid/inst/pc       : IF/ID pipeline register
//   dbg_state_o              : current fetch state, for observation
// Handshake: a request is presented while imem_req=1 and completes on the
// cycle imem_ack=1; imem_addr does not change while imem_req=1 and no ack.
module fetch_pc
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = core_pkg::NOP_INST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   PCSel,
  input  logic [31:0]  BrTarget,
  input  logic [31:0]  JalrTarget,
  input  logic         Stall,
  output logic         imem_req,
  output logic [31:0]  imem_addr,
  input  logic         imem_ack,
  input  logic [31:0]  imem_rdata,
  output logic         Flush,
  output logic         IfId_valid,
  output logic [31:0]  IfId_inst,
  output logic [31:0]  IfId_pc,
  output fetch_state_e dbg_state_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  pend_q, pend_d;
  logic [31:0]  buf_q, buf_d;
  logic         valid_q, valid_d;
  logic [31:0]  inst_q, inst_d;
  logic [31:0]  ifpc_q, ifpc_d;

  logic [31:0]  target;
  logic         redirect;

  pc_next_sel u_sel (
    .PCSel      (PCSel),
    .BrTarget   (BrTarget),
    .JalrTarget (JalrTarget),
    .target_o   (target),
    .redirect_o (redirect)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    inst_d  = inst_q;
    ifpc_d  = ifpc_q;

    // Redirect beats Stall everywhere: bubble IF/ID, keep IfId_pc as is.
    if (redirect) begin
      valid_d = 1'b0;
      inst_d  = NOP_INST;
    end

    case (state_q)
      S_RST: begin
        state_d = S_REQ;
        if (redirect) pc_d = target;
      end
      S_REQ: begin
        if (imem_ack) begin
          if (redirect) begin
            pc_d = target;
          end else if (Stall) begin
            buf_d   = imem_rdata;
            state_d = S_HOLD;
          end else begin
            valid_d = 1'b1;
            inst_d  = imem_rdata;
            ifpc_d  = pc_q;
            pc_d    = pc_q + 32'd4;
          end
        end else if (redirect) begin
          // Address must stay stable until the ack, so park the target.
          pend_d  = target;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        if (redirect) pend_d = target;
        if (imem_ack) begin
          // Same-cycle redirect is newer than anything parked in pend.
          pc_d    = redirect ? target : pend_q;
          state_d = S_REQ;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (!Stall) begin
          valid_d = 1'b1;
          inst_d  = buf_q;
          ifpc_d  = pc_q;
          pc_d    = pc_q + 32'd4;
          state_d = S_REQ;
        end
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      pend_q  <= RESET_PC;
      buf_q   <= NOP_INST;
      valid_q <= 1'b0;
      inst_q  <= NOP_INST;
      ifpc_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
      inst_q  <= inst_d;
      ifpc_q  <= ifpc_d;
    end
  end

  assign imem_req    = (state_q == S_REQ) || (state_q == S_DROP);
  assign imem_addr   = pc_q;
  assign Flush       = redirect;
  assign IfId_valid  = valid_q;
  assign IfId_inst   = inst_q;
  assign IfId_pc     = ifpc_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_pc.sv
// Directed bench for fetch_pc: a vector table applied one cycle per entry,
// then a hand-written async-reset-in-S_DROP sequence.
module tb_fetch_pc;
  import core_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   PCSel;
  logic [31:0]  BrTarget, JalrTarget;
  logic         Stall;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  logic         Flush;
  logic         IfId_valid;
  logic [31:0]  IfId_inst, IfId_pc;
  fetch_state_e dbg_state;

  fetch_pc #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst         (rst),
    .PCSel       (PCSel),
    .BrTarget    (BrTarget),
    .JalrTarget  (JalrTarget),
    .Stall       (Stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Flush       (Flush),
    .IfId_valid  (IfId_valid),
    .IfId_inst   (IfId_inst),
    .IfId_pc     (IfId_pc),
    .dbg_state_o (dbg_state)
  );

  // scoreboard counters
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  pcsel;
    logic [31:0] br;
    logic [31:0] jalr;
    logic        stall;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_flush;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] pcsel, input logic [31:0] br, input logic [31:0] jalr,
                     input logic stall, input logic ack, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr, input logic e_flush,
                     input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc);
    vec_t v;
    v.pcsel = pcsel; v.br = br; v.jalr = jalr; v.stall = stall; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_flush = e_flush;
    v.e_valid = e_valid; v.e_inst = e_inst; v.e_pc = e_pc;
    vecs.push_back(v);
  endtask

  // driver
  task automatic drive(input vec_t v);
    PCSel      = v.pcsel;
    BrTarget   = v.br;
    JalrTarget = v.jalr;
    Stall      = v.stall;
    imem_ack   = v.ack;
    imem_rdata = v.rdata;
  endtask

  initial begin
    PCSel = 2'b00; BrTarget = '0; JalrTarget = '0; Stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = '0;

    // Columns: pcsel br jalr stall ack rdata | req addr flush (this cycle) | valid inst pc (after edge)
    // reset -> first fetch
    add(2'b00, 0, 0, 0, 0, 0,            0, 32'h100, 0,  0, NOP, 0);
    add(2'b00, 0, 0, 0, 1, 32'h00500093, 1, 32'h100, 0,  1, 32'h00500093, 32'h100);
    // branch with coincident ack, then jalr (bit 0 cleared)
    add(2'b01, 32'h200, 0, 0, 1, 32'h00a00113, 1, 32'h104, 1,  0, NOP, 32'h100);
    add(2'b10, 0, 32'h301, 0, 1, 32'h11111111, 1, 32'h200, 1,  0, NOP, 32'h100);
    add(2'b00, 0, 0, 0, 1, 32'h22222222, 1, 32'h300, 0,  1, 32'h22222222, 32'h300);
    add(2'b10, 0, 32'h109, 0, 1, 32'h0, 1, 32'h304, 1,  0, NOP, 32'h300);
    // redirect while fetch at 0x108 outstanding, ack 3 cycles later
    add(2'b01, 32'h200, 0, 0, 0, 32'h0, 1, 32'h108, 1,  0, NOP, 32'h300);
    add(2'b00, 0, 0, 0, 0, 32'h0, 1, 32'h108, 0,  0, NOP, 32'h300);
    add(2'b00, 0, 0, 0, 0, 32'h0, 1, 32'h108, 0,  0, NOP, 32'h300);
    add(2'b00, 0, 0, 0, 1, 32'h33333333, 1, 32'h108, 0,  0, NOP, 32'h300);
    add(2'b00, 0, 0, 0, 1, 32'h44444444, 1, 32'h200, 0,  1, 32'h44444444, 32'h200);
    // stall on ack at 0x10C for 2 cycles
    add(2'b01, 32'h10C, 0, 0, 1, 32'h0, 1, 32'h204, 1,  0, NOP, 32'h200);
    add(2'b00, 0, 0, 1, 1, 32'h55555555, 1, 32'h10C, 0,  0, NOP, 32'h200);
    add(2'b00, 0, 0, 1, 0, 32'h0, 0, 32'h10C, 0,  0, NOP, 32'h200);
    add(2'b00, 0, 0, 0, 0, 32'h0, 0, 32'h10C, 0,  1, 32'h55555555, 32'h10C);
    add(2'b00, 0, 0, 0, 1, 32'h66666666, 1, 32'h110, 0,  1, 32'h66666666, 32'h110);
    // two redirects during S_DROP: latest wins
    add(2'b01, 32'h400, 0, 0, 0, 32'h0, 1, 32'h114, 1,  0, NOP, 32'h110);
    add(2'b10, 0, 32'h501, 0, 0, 32'h0, 1, 32'h114, 1,  0, NOP, 32'h110);
    add(2'b00, 0, 0, 0, 1, 32'hdeadbeef, 1, 32'h114, 0,  0, NOP, 32'h110);
    add(2'b00, 0, 0, 0, 1, 32'h77777777, 1, 32'h500, 0,  1, 32'h77777777, 32'h500);
    // PC wrap at 0xFFFFFFFC, and PCSel=11 is sequential
    add(2'b10, 0, 32'hFFFFFFFD, 0, 1, 32'h0, 1, 32'h504, 1,  0, NOP, 32'h500);
    add(2'b00, 0, 0, 0, 1, 32'h88888888, 1, 32'hFFFFFFFC, 0,  1, 32'h88888888, 32'hFFFFFFFC);
    add(2'b11, 32'h900, 32'h900, 0, 0, 32'h0, 1, 32'h0, 0,  1, 32'h88888888, 32'hFFFFFFFC);
    // redirect beats stall in S_HOLD
    add(2'b00, 0, 0, 1, 1, 32'h99999999, 1, 32'h0, 0,  1, 32'h88888888, 32'hFFFFFFFC);
    add(2'b01, 32'h600, 0, 1, 0, 32'h0, 0, 32'h0, 1,  0, NOP, 32'hFFFFFFFC);
    add(2'b00, 0, 0, 0, 1, 32'hAAAAAAAA, 1, 32'h600, 0,  1, 32'hAAAAAAAA, 32'h600);
    // enter S_DROP for the async reset sequence
    add(2'b01, 32'h700, 0, 0, 0, 32'h0, 1, 32'h604, 1,  0, NOP, 32'h600);

    // reset values while rst is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req",   {31'd0, imem_req},   32'd0);
    chk("rst_addr",  imem_addr,           RPC);
    chk("rst_valid", {31'd0, IfId_valid}, 32'd0);
    chk("rst_inst",  IfId_inst,           NOP);
    chk("rst_pc",    IfId_pc,             32'd0);
    chk("rst_state", {30'd0, dbg_state},  {30'd0, S_RST});
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d_req", i),   {31'd0, imem_req},   {31'd0, vecs[i].e_req});
      chk($sformatf("v%0d_addr", i),  imem_addr,           vecs[i].e_addr);
      chk($sformatf("v%0d_flush", i), {31'd0, Flush},      {31'd0, vecs[i].e_flush});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, IfId_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_inst", i),  IfId_inst,           vecs[i].e_inst);
      chk($sformatf("v%0d_pc", i),    IfId_pc,             vecs[i].e_pc);
      @(negedge clk);
    end

    // async reset in S_DROP: outputs reset before any clock edge
    PCSel = 2'b00; Stall = 1'b0; imem_ack = 1'b0;
    #1;
    chk("drop_state", {30'd0, dbg_state}, {30'd0, S_DROP});
    chk("drop_req",   {31'd0, imem_req},  32'd1);
    rst = 1'b1;
    #1;
    chk("arst_req",   {31'd0, imem_req},   32'd0);
    chk("arst_addr",  imem_addr,           RPC);
    chk("arst_valid", {31'd0, IfId_valid}, 32'd0);
    chk("arst_inst",  IfId_inst,           NOP);
    chk("arst_pc",    IfId_pc,             32'd0);
    chk("arst_state", {30'd0, dbg_state},  {30'd0, S_RST});
    // late ack arrives during and right after reset: must be ignored
    imem_ack = 1'b1; imem_rdata = 32'hBBBBBBBB;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("late_ack_valid", {31'd0, IfId_valid}, 32'd0);
    chk("late_ack_inst",  IfId_inst,           NOP);
    chk("refetch_addr",   imem_addr,           RPC);
    chk("refetch_state",  {30'd0, dbg_state},  {30'd0, S_REQ});
    @(negedge clk);
    imem_rdata = 32'hCCCCCCCC;
    @(posedge clk);
    #1;
    chk("refetch_valid", {31'd0, IfId_valid}, 32'd1);
    chk("refetch_inst",  IfId_inst,           32'hCCCCCCCC);
    chk("refetch_pc",    IfId_pc,             RPC);
    chk("refetch_next",  imem_addr,           32'h104);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
